// File: rtl/uart_tx_fsm_serializer.sv
// UART TX frame sequencer/serializer: start, LSB-first data, optional parity, stop; one bit per CLK.
// Define UART_TX_BACK2BACK_EN to let a new request in STOP chain straight into the next frame.
module uart_tx_fsm_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  BUSY
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_bit_cnt;
    logic                  par_en_reg;
    logic                  par_bit_reg;
    logic                  accept;

    // Frame configuration is captured only on accept so producer changes mid-frame are harmless.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
        end else begin
            state   <= next_state;
            bit_cnt <= next_bit_cnt;
            if (accept) begin
                data_reg    <= P_DATA;
                par_en_reg  <= PAR_EN;
                par_bit_reg <= (^P_DATA) ^ PAR_TYP;
            end
        end
    end

    always_comb begin
        next_state   = state;
        next_bit_cnt = bit_cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    accept     = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                next_state   = DATA;
                next_bit_cnt = '0;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    next_bit_cnt = '0;
                    next_state   = par_en_reg ? PARITY : STOP;
                end else begin
                    next_bit_cnt = bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                next_state = STOP;
            end
            STOP: begin
`ifdef UART_TX_BACK2BACK_EN
                if (DATA_VALID) begin
                    accept     = 1'b1;
                    next_state = START;
                end else begin
                    next_state = IDLE;
                end
`else
                next_state = IDLE;
`endif
            end
            default: begin
                next_state   = IDLE;
                next_bit_cnt = '0;
            end
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        MUX_SEL  = 2'b01;
        SER_DATA = 1'b0;
        BUSY     = 1'b1;
        case (state)
            IDLE:    BUSY = 1'b0;
            START:   MUX_SEL = 2'b00;
            DATA: begin
                MUX_SEL  = 2'b10;
                SER_DATA = data_reg[bit_cnt];
            end
            PARITY:  MUX_SEL = 2'b11;
            STOP:    MUX_SEL = 2'b01;
            default: BUSY = 1'b0;
        endcase
    end

    assign PAR_BIT = par_bit_reg;

endmodule

// File: tb/tb_uart_tx_fsm_serializer.sv
// Directed self-checking bench for uart_tx_fsm_serializer (DATA_WIDTH = 8).
// Honours UART_TX_BACK2BACK_EN to select the expected inter-frame gap.
module tb_uart_tx_fsm_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [1:0] MUX_SEL;
    logic       SER_DATA;
    logic       PAR_BIT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    uart_tx_fsm_serializer #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .MUX_SEL   (MUX_SEL),
        .SER_DATA  (SER_DATA),
        .PAR_BIT   (PAR_BIT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic dv, input logic [7:0] data, input logic pe, input logic pt);
        DATA_VALID = dv;
        P_DATA     = data;
        PAR_EN     = pe;
        PAR_TYP    = pt;
    endtask

    task automatic chk(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] mux, input logic busy,
                               input logic ser, input logic par);
        chk({tag, ".mux"},  MUX_SEL,         mux);
        chk({tag, ".busy"}, {1'b0, BUSY},     {1'b0, busy});
        chk({tag, ".ser"},  {1'b0, SER_DATA}, {1'b0, ser});
        chk({tag, ".par"},  {1'b0, PAR_BIT},  {1'b0, par});
    endtask

    // Walks the eight DATA cycles, comparing each serial bit against the bench's own word.
    task automatic dataBits(input string tag, input logic [7:0] word, input logic par);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("%s.d%0d", tag, i), 2'b10, 1'b1, word[i], par);
        end
    endtask

    // Full frame from an idle DUT: request at edge k, START at k+1, then data, optional parity, stop, idle.
    task automatic runFrame(input string tag, input logic [7:0] word, input logic pe,
                            input logic pt, input logic par);
        applyStimulus(1'b1, word, pe, pt);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput({tag, ".start"}, 2'b00, 1'b1, 1'b0, par);
        dataBits(tag, word, par);
        if (pe) begin
            tick();
            checkOutput({tag, ".parity"}, 2'b11, 1'b1, 1'b0, par);
        end
        tick();
        checkOutput({tag, ".stop"}, 2'b01, 1'b1, 1'b0, par);
        tick();
        checkOutput({tag, ".idle"}, 2'b01, 1'b0, 1'b0, par);
    endtask

    initial begin
        $display("[TB] start");

        // Reset held two cycles with a competing request: reset wins.
        RST = 1'b1;
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("reset", 2'b01, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("post_reset", 2'b01, 1'b0, 1'b0, 1'b0);

        // 0xA5: four ones, so even parity bit = 0.
        runFrame("nopar_A5", 8'hA5, 1'b0, 1'b0, 1'b0);
        runFrame("even_A5", 8'hA5, 1'b1, 1'b0, 1'b0);
        // 0x07: three ones -> odd parity 0, even parity 1.
        runFrame("odd_07", 8'h07, 1'b1, 1'b1, 1'b0);
        runFrame("even_07", 8'h07, 1'b1, 1'b0, 1'b1);

        // Busy ignore: 0x3C with odd type (parity 1) and a stray 0xFF request mid-frame.
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("busy.start", 2'b00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("busy.d%0d", i), 2'b10, 1'b1, (i == 2 || i == 3 || i == 4 || i == 5) ? 1'b1 : 1'b0, 1'b1);
            if (i == 2) applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
            if (i == 3) applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
        end
        tick();
        checkOutput("busy.stop", 2'b01, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("busy.idle1", 2'b01, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("busy.idle2", 2'b01, 1'b0, 1'b0, 1'b1);

        // Reset during the 4th data bit of 0x96 (odd parity -> 1), then a clean retry.
        applyStimulus(1'b1, 8'h96, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("abort.start", 2'b00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("abort.d%0d", i), 2'b10, 1'b1, (i == 1 || i == 2) ? 1'b1 : 1'b0, 1'b1);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("abort.reset", 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("abort.idle", 2'b01, 1'b0, 1'b0, 1'b0);
        runFrame("retry_96", 8'h96, 1'b1, 1'b1, 1'b1);

        // Request held high across two frames: 0x55 then 0xAA, no parity.
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput("b2b1.start", 2'b00, 1'b1, 1'b0, 1'b0);
        dataBits("b2b1", 8'h55, 1'b0);
        tick();
        checkOutput("b2b1.stop", 2'b01, 1'b1, 1'b0, 1'b0);
`ifndef UART_TX_BACK2BACK_EN
        tick();
        checkOutput("b2b.gap", 2'b01, 1'b0, 1'b0, 1'b0);
`endif
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("b2b2.start", 2'b00, 1'b1, 1'b0, 1'b0);
        dataBits("b2b2", 8'hAA, 1'b0);
        tick();
        checkOutput("b2b2.stop", 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b2b2.idle", 2'b01, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
